// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, defaults and counter-width helpers.
// Defaults match the transmitter's frame shape and oversample rate.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  function automatic int tick_w(input int os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

  function automatic int bit_w(input int nb);
    return $clog2(nb + 1);
  endfunction

  localparam int UART_TICK_W = tick_w(UART_OVERSAMPLE);
  localparam int UART_BIT_W  = bit_w(UART_DATA_BITS);

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for the asynchronous rx line.
// Flops reset to 1 so a reset never looks like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic [STAGES-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) q <= '1;
    else     q <= {q[STAGES-2:0], rx};
  end

  assign rx_s = q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver with valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit and parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
`ifdef UART_RX_PARITY_EN
  parameter bit PARITY_ODD  = 1'b0,
`endif
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TW = tick_w(OVERSAMPLE);
  localparam int BW = bit_w(DATA_BITS);

  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 commit;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .rx_s(rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      commit    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      commit    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= commit &&
        ((^shreg ^ par_bit) != PARITY_ODD);
`endif
      // Same-cycle drain lets a new byte replace the old one.
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (baud_tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == T_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == B_END) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              if (rx_s) begin
                commit <= 1'b1;
                state  <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          // A held-low line (break) must go high before re-arming.
          WAIT_HIGH: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a scoreboard of expected receiver events.
// Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  typedef enum int {EV_LOAD, EV_FERR, EV_OVR, EV_PERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic pv = 1'b0;
  logic pr = 1'b0;

  task automatic expect_ev(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic got(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got %s/%h required none", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d) begin
        n_bad++;
        $display("FAIL event: got %s/%h required %s/%h",
                 k.name(), d, e.kind.name(), e.data);
      end
    end
  endtask

  // Monitor: turns output activity into events and scores them.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) got(EV_FERR, 8'h00);
      if (overrun) got(EV_OVR, rx_data);
`ifdef UART_RX_PARITY_EN
      if (parity_err) got(EV_PERR, 8'h00);
`endif
      if (rx_valid && (!pv || pr)) got(EV_LOAD, rx_data);
    end
    pv = rx_valid;
    pr = rx_ready;
  end

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_data(input logic [7:0] d);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit use_par = 1'b0,
                            input bit par = 1'b0);
    send_data(d);
    if (use_par) send_bit(par, 16);
    send_bit(1'b1, 16);
    send_bit(1'b1, 20);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("drain_valid", rx_valid, 0);
  endtask

  task automatic ready_at_commit();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("busy_rise", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("busy_fall", ok, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] part;
    part = 8'h96;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    send_bit(1'b1, 10);

    expect_ev(EV_LOAD, 8'hA5);
    send_frame(8'hA5);
    check("a5_busy", busy, 0);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    drain();

    send_bit(1'b0, 6);
    send_bit(1'b1, 30);
    check("false_busy", busy, 0);
    check("false_valid", rx_valid, 0);

    expect_ev(EV_FERR, 8'h00);
    send_data(8'h3C);
    send_bit(1'b0, 30);
    check("brk_busy", busy, 1);
    send_bit(1'b0, 10);
    send_bit(1'b1, 20);
    check("brk_idle", busy, 0);
    check("brk_valid", rx_valid, 0);

    expect_ev(EV_LOAD, 8'h11);
    expect_ev(EV_OVR, 8'h11);
    send_frame(8'h11);
    send_frame(8'h22);
    check("ovr_data", rx_data, 8'h11);
    drain();

    expect_ev(EV_LOAD, 8'h11);
    send_frame(8'h11);
    expect_ev(EV_LOAD, 8'h22);
    fork
      send_frame(8'h22);
      ready_at_commit();
    join
    check("swap_data", rx_data, 8'h22);
    check("swap_valid", rx_valid, 1);

    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(part[i], 16);
    send_bit(part[4], 8);
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    send_bit(1'b1, 20);
    expect_ev(EV_LOAD, 8'h5A);
    send_frame(8'h5A);
    check("5a_data", rx_data, 8'h5A);
    drain();

`ifdef UART_RX_PARITY_EN
    expect_ev(EV_PERR, 8'h00);
    expect_ev(EV_LOAD, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_bad_data", rx_data, 8'h07);
    drain();
    expect_ev(EV_LOAD, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_ok_data", rx_data, 8'h07);
    drain();
`endif

    send_bit(1'b1, 20);
    check("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the serial-input counterpart of the baud tick generator.
- Consumes the 16x oversample tick from Baud_Tick and the asynchronous rx line.
- Recovers 8N1 frames (start, LSB-first data, stop) and presents each byte on a valid/ready holding register.
- Flags framing errors and overruns; sits between the pad/synchronizer and the consuming FIFO or CSR block.

Parameters:
- DATA_BITS, 8: data bits per frame (5..9).
- OVERSAMPLE, 16: ticks per bit period; must match the tick generator. Even, >= 4.
- SYNC_STAGES, 2: synchronizer flops on rx (>= 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-cycle oversample strobe, OVERSAMPLE per bit period.
- rx  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts on rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: frame completed while holding register full and not drained.
- busy  output  1  high in any state other than IDLE.

Behaviour:
Interface:
- One clock: clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, tick counter 0, bit counter 0, shift register 0, synchronizer flops 1.

Sampling:
- rx passes through SYNC_STAGES flops; rx_s is the last stage. All decisions use rx_s.
- The state machine advances only in cycles where baud_tick=1. rx_ready handling is evaluated every cycle.

State machine:
- IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
- START: count ticks to OVERSAMPLE/2-1 (mid-bit).
  - rx_s=0 at mid-bit: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1 at mid-bit: false start; return to IDLE with no flags.
- DATA: on every OVERSAMPLE-th tick, shift rx_s into the MSB of the shift register (LSB-first arrival). After DATA_BITS samples go to PARITY (if enabled) or STOP.
- STOP: sample on the OVERSAMPLE-th tick.
  - rx_s=1: commit the frame, then go to IDLE.
  - rx_s=0: pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick with rx_s=1, then go to IDLE. This prevents a break condition from retriggering.

Commit and handshake:
- Commit occurs in the cycle after the final stop tick.
- rx_valid=0: load rx_data and set rx_valid.
- rx_valid=1 and rx_ready=0: keep the old data, pulse overrun, drop the new byte.
- rx_valid=1 and rx_ready=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
- A handshake with no commit clears rx_valid in the next cycle.
- rx_ready while rx_valid=0 is ignored.

Reset and tick timing:
- rst asserted mid-frame: return to IDLE on the next clk edge, clear all outputs, discard the partial byte.
- baud_tick held high continuously is legal (fastest simulation rate). All counts are in ticks, never in clk cycles.

Optional Feature:
UART_RX_PARITY_EN
- Defined: adds the PARITY state after DATA and a parameter PARITY_ODD (default 0 = even). The parity bit is sampled like a data bit.
- On mismatch: pulse parity_err (extra 1-bit output) at commit time. The byte is still delivered (or causes overrun) normally.
- Undefined: no PARITY state, no parity_err port; frame is exactly 8N1.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}.
  - Localparam helpers for counter widths, $clog2(OVERSAMPLE) and $clog2(DATA_BITS+1).
  - Shared defaults for DATA_BITS and OVERSAMPLE so they match the transmitter.
- Sub-module uart_rx_sync: SYNC_STAGES-deep synchronizer, reset to 1, output rx_s. It is the only sub-module.

Test Plan (OVERSAMPLE=16; bench drives baud_tick every cycle unless stated):
- Frame 0xA5 (rx bits 0,1,0,1,0,0,1,0,1,1), rx_ready=0 -> rx_valid=1, rx_data=0xA5, busy falls, no error pulses.
- rx low for 6 ticks then high -> START aborts at mid-bit, back to IDLE; rx_valid, frame_err, overrun all stay 0.
- Frame 0x3C with stop bit held low for 40 ticks -> frame_err one cycle, rx_valid stays 0, busy=1 until rx_s high, then IDLE.
- Frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x11, overrun pulses once. Repeat with rx_ready=1 in the commit cycle -> rx_data=0x22, no overrun.
- rst pulsed for one cycle during bit 4 of a frame, then a clean 0x5A frame -> outputs cleared after reset; 0x5A received correctly.
- With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 sent with parity 0 -> rx_data=0x07, parity_err pulses. Same byte with parity 1 -> no pulse.
